// File: rtl/seq_subtractor_if.sv
// Operand/result handshake bundle for seq_subtractor: valid/ready on the input
// side (operands) and on the output side (difference, borrow, overflow).
interface seq_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             borrow_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] diff_o;
  logic             borrow_o;
  logic             overflow_o;

  modport slave (
    input  in_valid_i, a_i, b_i, borrow_i, out_ready_i,
    output in_ready_o, out_valid_o, diff_o, borrow_o, overflow_o
  );

  modport master (
    output in_valid_i, a_i, b_i, borrow_i, out_ready_i,
    input  in_ready_o, out_valid_o, diff_o, borrow_o, overflow_o
  );
endinterface

// File: rtl/seq_subtractor.sv
// Multi-cycle a - b - borrow_in: a ripple of BITS_PER_CYCLE full-subtractor cells
// is applied slice by slice, LSB first, with the borrow carried in a register.
module seq_subtractor #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1,
  parameter bit SIGNED         = 1'b0
) (
  input logic             clk_i,
  input logic             rst_n_i,
  seq_subtractor_if.slave bus
);

  localparam int N   = WIDTH / BITS_PER_CYCLE;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int MSB = WIDTH - 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 1 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_param_chk
    $error("seq_subtractor: BITS_PER_CYCLE must be >= 1 and divide WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0]          r_a;
  logic [WIDTH-1:0]          r_b;
  logic [WIDTH-1:0]          r_acc;
  logic [WIDTH-1:0]          r_diff;
  logic                      r_bin;
  logic                      r_borrow;
  logic                      r_ovf;
  logic [CW-1:0]             r_cnt;

  int                        w_base;
  logic [BITS_PER_CYCLE-1:0] w_x;
  logic [BITS_PER_CYCLE-1:0] w_y;
  logic [BITS_PER_CYCLE-1:0] w_sd;
  logic                      w_bout;
  logic [WIDTH-1:0]          w_acc_nxt;
  logic                      w_last;
  logic                      w_ovf;

  // Ripple of full-subtractor cells; returns {borrow_out, diff_slice}.
  function automatic logic [BITS_PER_CYCLE:0] sub_slice(
    input logic [BITS_PER_CYCLE-1:0] x,
    input logic [BITS_PER_CYCLE-1:0] y,
    input logic                      bin
  );
    logic [BITS_PER_CYCLE-1:0] d;
    logic                      c;
    c = bin;
    d = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      d[i] = x[i] ^ y[i] ^ c;
      c    = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & c);
    end
    return {c, d};
  endfunction

  always_comb begin
    w_base    = int'(r_cnt) * BITS_PER_CYCLE;
    w_x       = r_a[w_base +: BITS_PER_CYCLE];
    w_y       = r_b[w_base +: BITS_PER_CYCLE];
    {w_bout, w_sd} = sub_slice(w_x, w_y, r_bin);
    w_acc_nxt = r_acc;
    w_acc_nxt[w_base +: BITS_PER_CYCLE] = w_sd;
    w_last    = (r_cnt == LAST);
    // Signed overflow: operands of opposite sign and the result sign flipped away from a.
    w_ovf     = SIGNED ? ((r_a[MSB] != r_b[MSB]) && (w_acc_nxt[MSB] != r_a[MSB])) : w_bout;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    bus.in_ready_o  = 1'b0;
    bus.out_valid_o = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        bus.in_ready_o = 1'b1;
        if (bus.in_valid_i) w_state_nxt = S_CALC;
      end
      S_CALC: begin
        if (w_last) w_state_nxt = S_CALC == r_state ? S_DONE : S_CALC;
      end
      S_DONE: begin
        bus.out_valid_o = 1'b1;
        if (bus.out_ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_diff   <= '0;
      r_bin    <= 1'b0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
      r_cnt    <= '0;
    end else if (r_state == S_IDLE && bus.in_valid_i) begin
      r_a   <= bus.a_i;
      r_b   <= bus.b_i;
      r_bin <= bus.borrow_i;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == S_CALC) begin
      r_acc <= w_acc_nxt;
      r_bin <= w_bout;
      r_cnt <= r_cnt + 1'b1;
      // Published results only move on the final slice; they hold otherwise.
      if (w_last) begin
        r_diff   <= w_acc_nxt;
        r_borrow <= w_bout;
        r_ovf    <= w_ovf;
      end
    end
  end

  assign bus.diff_o     = r_diff;
  assign bus.borrow_o   = r_borrow;
  assign bus.overflow_o = r_ovf;

endmodule

// File: tb/tb_seq_subtractor.sv
// Bench for seq_subtractor: four lanes with different WIDTH/BITS_PER_CYCLE/SIGNED,
// a queue-based scoreboard fed at issue time and drained by a negedge monitor.
module tb_seq_subtractor;

  localparam int NL = 4;
  localparam int W_T [NL] = '{1, 8, 8, 8};
  localparam int B_T [NL] = '{1, 1, 4, 8};
  localparam int S_T [NL] = '{0, 0, 1, 0};

  typedef struct packed {
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NL-1:0]       iv_d;
  logic [NL-1:0][7:0]  a_d;
  logic [NL-1:0][7:0]  b_d;
  logic [NL-1:0]       bin_d;
  logic [NL-1:0]       ordy_d;
  logic [NL-1:0]       rnd_ordy;
  logic [NL-1:0]       ordy_eff;
  logic                rand_bp;

  logic [NL-1:0]       irdy;
  logic [NL-1:0]       ov;
  logic [NL-1:0][7:0]  dif;
  logic [NL-1:0]       bo;
  logic [NL-1:0]       of;

  assign ordy_eff = rand_bp ? rnd_ordy : ordy_d;

  for (genvar g = 0; g < NL; g++) begin : g_lane
    localparam int W = W_T[g];
    seq_subtractor_if #(.WIDTH(W)) bus ();
    seq_subtractor #(
      .WIDTH(W), .BITS_PER_CYCLE(B_T[g]), .SIGNED(S_T[g] != 0)
    ) dut (
      .clk_i  (clk),
      .rst_n_i(rst_n),
      .bus    (bus)
    );
    assign bus.in_valid_i  = iv_d[g];
    assign bus.a_i         = a_d[g][W-1:0];
    assign bus.b_i         = b_d[g][W-1:0];
    assign bus.borrow_i    = bin_d[g];
    assign bus.out_ready_i = ordy_eff[g];
    assign irdy[g]         = bus.in_ready_o;
    assign ov[g]           = bus.out_valid_o;
    assign dif[g]          = 8'(bus.diff_o);
    assign bo[g]           = bus.borrow_o;
    assign of[g]           = bus.overflow_o;
  end

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t sbq  [NL][$];
  int   accq [NL][$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values, range check for signed overflow.
  function automatic exp_t model(input int l, input logic [7:0] a, input logic [7:0] b, input logic bin);
    exp_t e;
    int w    = W_T[l];
    int mask = (1 << w) - 1;
    int ua   = int'(a) & mask;
    int ub   = int'(b) & mask;
    int full = ua - ub - int'(bin);
    int sa, sb, sr;
    e.d  = 8'(full & mask);
    e.bo = (full < 0);
    if (S_T[l] != 0) begin
      sa   = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
      sb   = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
      sr   = sa - sb - int'(bin);
      e.ov = (sr < -(1 << (w - 1))) || (sr > (1 << (w - 1)) - 1);
    end else begin
      e.ov = e.bo;
    end
    return e;
  endfunction

  initial begin
    rnd_ordy = '1;
    forever begin
      @(posedge clk); #1;
      for (int l = 0; l < NL; l++) rnd_ordy[l] = ($urandom_range(0, 3) != 0);
    end
  end

  logic [7:0] h_d [NL];
  logic       h_b [NL];
  logic       h_o [NL];
  logic       p_ov[NL];
  logic       p_hs[NL];

  always @(negedge clk) begin
    for (int l = 0; l < NL; l++) begin
      if (!rst_n) begin
        sbq[l].delete();
        accq[l].delete();
        p_ov[l] = 1'b0; p_hs[l] = 1'b0;
        h_d[l] = '0; h_b[l] = 1'b0; h_o[l] = 1'b0;
      end else begin
        exp_t e;
        int   t0;
        if (p_ov[l] && !p_hs[l]) chk($sformatf("lane%0d valid held", l), ov[l], 1);
        if (ov[l] && !p_ov[l]) begin
          if (accq[l].size() == 0) chk($sformatf("lane%0d result without accept", l), 0, 1);
          else begin
            t0 = accq[l].pop_front();
            chk($sformatf("lane%0d latency", l), cyc - t0 - 1, W_T[l] / B_T[l]);
          end
        end else begin
          chk($sformatf("lane%0d outputs held", l), {dif[l], bo[l], of[l]}, {h_d[l], h_b[l], h_o[l]});
        end
        if (ov[l]) chk($sformatf("lane%0d in_ready in DONE", l), irdy[l], 0);
        if (irdy[l] && iv_d[l]) accq[l].push_back(cyc);
        if (ov[l] && ordy_eff[l]) begin
          if (sbq[l].size() == 0) chk($sformatf("lane%0d unexpected result", l), 1, 0);
          else begin
            e = sbq[l].pop_front();
            chk($sformatf("lane%0d diff", l), dif[l], e.d);
            chk($sformatf("lane%0d borrow", l), bo[l], e.bo);
            chk($sformatf("lane%0d overflow", l), of[l], e.ov);
          end
        end
        p_ov[l] = ov[l];
        p_hs[l] = ov[l] && ordy_eff[l];
        h_d[l] = dif[l]; h_b[l] = bo[l]; h_o[l] = of[l];
      end
    end
  end

  task automatic issue(input int l, input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input bit push);
    int t = 0;
    @(posedge clk); #1;
    a_d[l] = a; b_d[l] = b; bin_d[l] = bin; iv_d[l] = 1'b1;
    if (push) sbq[l].push_back(model(l, a, b, bin));
    @(negedge clk);
    while (!irdy[l] && t < 200) begin @(negedge clk); t++; end
    if (!irdy[l]) chk($sformatf("lane%0d accept timeout", l), 0, 1);
    @(posedge clk); #1;
    iv_d[l] = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    int left;
    do begin
      @(negedge clk);
      left = 0;
      for (int l = 0; l < NL; l++) left += sbq[l].size();
      t++;
    end while (left != 0 && t < 1000);
    chk("drain pending results", left, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_n = 1'b0; rand_bp = 1'b0;
    iv_d = '0; a_d = '0; b_d = '0; bin_d = '0; ordy_d = '1;
    #12;
    for (int l = 0; l < NL; l++) begin
      chk($sformatf("lane%0d reset in_ready", l), irdy[l], 1);
      chk($sformatf("lane%0d reset out_valid", l), ov[l], 0);
      chk($sformatf("lane%0d reset diff", l), dif[l], 0);
      chk($sformatf("lane%0d reset borrow", l), bo[l], 0);
      chk($sformatf("lane%0d reset overflow", l), of[l], 0);
    end
    #10 rst_n = 1'b1;

    // Directed cases
    issue(0, 8'h0, 8'h0, 1'b0, 1); issue(0, 8'h0, 8'h1, 1'b0, 1);
    issue(0, 8'h1, 8'h0, 1'b0, 1); issue(0, 8'h1, 8'h1, 1'b0, 1);
    issue(0, 8'h0, 8'h0, 1'b1, 1); issue(0, 8'h1, 8'h1, 1'b1, 1);
    issue(1, 8'h05, 8'h03, 1'b0, 1); issue(1, 8'h03, 8'h05, 1'b0, 1);
    issue(1, 8'h00, 8'h00, 1'b1, 1);
    issue(2, 8'h80, 8'h01, 1'b0, 1); issue(2, 8'h7F, 8'hFF, 1'b0, 1);
    issue(2, 8'h05, 8'h07, 1'b0, 1); issue(2, 8'h10, 8'h01, 1'b0, 1);
    issue(2, 8'h80, 8'h00, 1'b1, 1);
    issue(3, 8'h10, 8'h01, 1'b0, 1); issue(3, 8'h00, 8'hFF, 1'b1, 1);
    drain();

    // Random operands with random output backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 30; i++)
      for (int l = 0; l < NL; l++)
        issue(l, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1);
    drain();
    rand_bp = 1'b0;

    // Backpressure in DONE while new operands wait on the input
    @(posedge clk); #1;
    ordy_d[1] = 1'b0;
    issue(1, 8'h5A, 8'h21, 1'b0, 1);
    t = 0;
    while (!ov[1] && t < 50) begin @(negedge clk); t++; end
    chk("bp result valid", ov[1], 1);
    @(posedge clk); #1;
    a_d[1] = 8'h33; b_d[1] = 8'h11; bin_d[1] = 1'b0; iv_d[1] = 1'b1;
    sbq[1].push_back(model(1, 8'h33, 8'h11, 1'b0));
    repeat (5) begin
      @(negedge clk);
      chk("bp in_ready", irdy[1], 0);
      chk("bp out_valid", ov[1], 1);
      chk("bp diff", dif[1], 8'h39);
    end
    @(posedge clk); #1;
    ordy_d[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp in_ready after handshake", irdy[1], 1);
    @(posedge clk); #1;
    iv_d[1] = 1'b0;
    drain();

    // Asynchronous reset in the middle of CALC discards the operation
    issue(1, 8'h05, 8'h03, 1'b0, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset in_ready", irdy[1], 1);
    chk("midreset out_valid", ov[1], 0);
    chk("midreset diff", dif[1], 0);
    chk("midreset borrow", bo[1], 0);
    chk("midreset overflow", of[1], 0);
    @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    issue(1, 8'h09, 8'h04, 1'b0, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_subtractor.md
Name: seq_subtractor

Overview:
Parametrised multi-cycle N-bit subtractor. Computes diff = a - b - borrow_in by iterating a full-subtractor slice over the operands, LSB slice first, BITS_PER_CYCLE bits per clock. It uses valid/ready handshakes on both input and output so it can sit between pipeline stages in the arithmetic datapath. It also reports a borrow-out and a mode-dependent overflow flag.

Parameters:
WIDTH, 8, operand and result width in bits (>=1)
BITS_PER_CYCLE, 1, bits processed per CALC cycle; must divide WIDTH exactly (checked by elaboration assertion)
SIGNED, 0, 0 = unsigned overflow rule, 1 = two's-complement overflow rule

Ports:
clk_i  input  1  clock, rising edge
rst_n_i  input  1  asynchronous active-low reset
in_valid_i  input  1  operands valid
in_ready_o  output  1  block can accept operands
a_i  input  WIDTH  minuend
b_i  input  WIDTH  subtrahend
borrow_i  input  1  borrow-in, subtracted at bit 0
out_valid_o  output  1  result valid
out_ready_i  input  1  downstream accepts result
diff_o  output  WIDTH  difference a - b - borrow_i, modulo 2^WIDTH
borrow_o  output  1  borrow out of the MSB
overflow_o  output  1  overflow flag per SIGNED

Behaviour:
- Reset: the block has one clock, clk_i. Reset rst_n_i is asynchronous and active-low. While rst_n_i=0: state=IDLE, in_ready_o=1, out_valid_o=0, diff_o=0, borrow_o=0, overflow_o=0, and all internal registers = 0.
- Define N = WIDTH/BITS_PER_CYCLE. The FSM has three states: IDLE, CALC, DONE.
- IDLE:
  - in_ready_o=1.
  - On an edge with in_valid_i=1, register a_i, b_i and borrow_i, clear the slice counter, and go to CALC.
- CALC:
  - in_ready_o=0 and out_valid_o=0. in_valid_i and the operand inputs are ignored.
  - Each cycle computes slice k (bits k*BPC .. k*BPC+BPC-1) as a ripple of full-subtractor cells, with diff = x^y^bin and bout = (~x&y) | (~(x^y)&bin).
  - The running borrow is registered between slices. The counter increments each cycle.
  - After slice N-1, capture the final borrow, compute overflow, and go to DONE.
- DONE:
  - out_valid_o=1; diff_o, borrow_o and overflow_o are held stable; in_ready_o=0.
  - On an edge with out_ready_i=1, go to IDLE; out_valid_o falls and in_ready_o rises on the next cycle.
  - out_valid_o never drops without a handshake.
- Latency: the accept edge is cycle 0. out_valid_o is 1 after exactly N further edges. Throughput is at most one result per N+2 cycles (no overlap of accept and complete).
- Overflow rule:
  - SIGNED=0: overflow_o = borrow_o.
  - SIGNED=1: overflow_o = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), with borrow_i included in the arithmetic.
- diff_o, borrow_o and overflow_o change only on the transition into DONE. They hold their previous result in IDLE and CALC; they are 0 only after reset.
- Boundaries:
  - WIDTH=1: the block behaves as a registered full subtractor with N=1.
  - BPC=WIDTH: single CALC cycle.
  - Reset asserted mid-CALC or in DONE: immediate return to reset values and the result is discarded.
  - in_valid_i held high through a result: the next operands are accepted only in IDLE.

Test Plan:
- WIDTH=1, BPC=1, sweep of (a,b) = 00, 01, 10, 11 with borrow_i=0 → diff/borrow = 0/0, 1/1, 1/0, 0/0. out_valid_o rises 1 cycle after each accept.
- WIDTH=8, BPC=1, SIGNED=0:
  - 0x05 - 0x03, borrow_i=0 → diff_o=0x02, borrow_o=0, overflow_o=0, valid 8 cycles after accept.
  - 0x03 - 0x05 → 0xFE, borrow_o=1, overflow_o=1.
  - 0x00 - 0x00 with borrow_i=1 → 0xFF, borrow_o=1.
- WIDTH=8, SIGNED=1:
  - 0x80 - 0x01 → 0x7F, borrow_o=0, overflow_o=1.
  - 0x7F - 0xFF → 0x80, overflow_o=1.
  - 0x05 - 0x07 → 0xFE, overflow_o=0.
- WIDTH=8, BPC=4: 0x10 - 0x01 → 0x0F, out_valid_o exactly 2 cycles after accept. WIDTH=8, BPC=8: same result, 1 cycle after accept.
- Backpressure: hold out_ready_i=0 for 5 cycles in DONE while driving in_valid_i=1 with new operands. Required: outputs stable, in_ready_o=0, new operands not taken. Raise out_ready_i → IDLE next cycle, then the new operands are accepted.
- Assert rst_n_i low asynchronously (between edges) at CALC cycle 3 of a 0x05 - 0x03 op. Required: outputs go to reset values immediately and in_ready_o=1. After release, a fresh 0x09 - 0x04 op returns 0x05.
